// File: rtl/md_pkg.sv
// Shared constants for the Mega Drive six-button select sequencer and encoder.
// sel_decode maps the synchronised select level and edge count to a mux group.
package md_pkg;

    localparam int SEL_W = 3;
    localparam int CNT_W = 3;

    localparam logic [SEL_W-1:0] SEL_NORM_HI = 3'd0;
    localparam logic [SEL_W-1:0] SEL_NORM_LO = 3'd1;
    localparam logic [SEL_W-1:0] SEL_ID_LO   = 3'd2;
    localparam logic [SEL_W-1:0] SEL_EXT_HI  = 3'd3;
    localparam logic [SEL_W-1:0] SEL_EXT_LO  = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ID  = 3'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = 3'd4;

    localparam int TIMEOUT_CYCLES_DEF = 15000;

    function automatic logic [SEL_W-1:0] sel_decode(input logic lvl, input logic [CNT_W-1:0] cnt);
        logic [SEL_W-1:0] s;
        if (cnt == CNT_ID)
            s = lvl ? SEL_EXT_HI : SEL_ID_LO;
        else if ((cnt == CNT_MAX) && !lvl)
            s = SEL_EXT_LO;
        else
            s = lvl ? SEL_NORM_HI : SEL_NORM_LO;
        return s;
    endfunction

endpackage

// File: rtl/md_select_sequencer_if.sv
// Pin-7 / mode-button inputs and encoder-mux outputs of one controller port.
// master = console/pin side, slave = the sequencer.
interface md_select_sequencer_if;
    import md_pkg::*;

    logic             p7;
    logic             md;
    logic [SEL_W-1:0] sel;
    logic             p7_s;
    logic             six_mode;
    logic             tmo;

    modport master (output p7, md, input sel, p7_s, six_mode, tmo);
    modport slave  (input p7, md, output sel, p7_s, six_mode, tmo);

endinterface

// File: rtl/md_sync_edge.sv
// Multi-flop synchroniser with a history flop for edge detection.
// Edge pulses are decoded only from flop outputs, so they are glitch-free and line up with lvl_o.
module md_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], a_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/md_select_sequencer.sv
// Tracks the console select line, counts select cycles with timeout, and drives the encoder mux code.
// cnt | meaning: 0 idle/first phase, 1..2 normal phases, 3 ID-low/ext-high phase, 4 all-high nibble phase.
module md_select_sequencer
    import md_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int SYNC_STAGES    = 2
) (
    input logic                 clk,
    input logic                 rst,
    md_select_sequencer_if.slave sq
);

    localparam int              TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    logic             p7_lvl;
    logic             p7_fall;
    logic             p7_rise_unused;

    logic             p7_s_q, p7_s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             six_q, six_d;
    logic             latched_q;
    logic             tmo_q, tmo_d;

    md_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk    (clk),
        .rst    (rst),
        .a_i    (sq.p7),
        .lvl_o  (p7_lvl),
        .rise_o (p7_rise_unused),
        .fall_o (p7_fall)
    );

    always_comb begin
        six_d  = latched_q ? six_q : sq.md;
        p7_s_d = p7_lvl;
        cnt_d  = cnt_q;
        tmr_d  = tmr_q + 1'b1;
        tmo_d  = 1'b0;
        // a fall in the expiry cycle takes priority over the timeout
        if (p7_fall) begin
            tmr_d = '0;
            if (cnt_q != CNT_MAX)
                cnt_d = cnt_q + 1'b1;
        end else if (tmr_q == TMR_LAST) begin
            tmr_d = '0;
            cnt_d = '0;
            tmo_d = (cnt_q != '0);
        end
        if (!six_d)
            cnt_d = '0;
        sel_d = sel_decode(p7_s_d, cnt_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p7_s_q    <= 1'b0;
            cnt_q     <= '0;
            tmr_q     <= '0;
            sel_q     <= SEL_NORM_LO;
            six_q     <= 1'b1;
            latched_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            p7_s_q    <= p7_s_d;
            cnt_q     <= cnt_d;
            tmr_q     <= tmr_d;
            sel_q     <= sel_d;
            six_q     <= six_d;
            latched_q <= 1'b1;
            tmo_q     <= tmo_d;
        end
    end

    assign sq.sel      = sel_q;
    assign sq.p7_s     = p7_s_q;
    assign sq.six_mode = six_q;
    assign sq.tmo      = tmo_q;

endmodule

// File: tb/tb_md_select_sequencer.sv
// Bench for md_select_sequencer: random and directed select-line traffic against a
// per-edge reference model built from a sampled-pin history and an edge-age timeout.
module tb_md_select_sequencer;

    localparam int TMO = 1500;
    localparam int NS  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    md_select_sequencer_if sq_if ();

    md_select_sequencer #(.TIMEOUT_CYCLES(TMO), .SYNC_STAGES(NS)) dut (
        .clk (clk),
        .rst (rst),
        .sq  (sq_if.slave)
    );

    always #50 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // reference model state
    bit       pin_q[$];
    int       m_cnt, m_edge, m_last, m_tmo_count;
    bit       m_six, m_latched, m_prev_lvl, m_lvl, m_tmo;
    logic [2:0] m_sel;

    function automatic logic [2:0] exp_sel(input bit lvl, input int c);
        case (c)
            3:       return lvl ? 3'd3 : 3'd2;
            4:       return lvl ? 3'd0 : 3'd4;
            default: return lvl ? 3'd0 : 3'd1;
        endcase
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_edge = 0; m_last = 0;
        m_six = 1'b1; m_latched = 1'b0;
        m_prev_lvl = 1'b0; m_lvl = 1'b0; m_tmo = 1'b0;
        m_sel = 3'd1;
        pin_q.delete();
        for (int i = 0; i < NS; i++) pin_q.push_back(1'b0);
    endtask

    always @(posedge clk) begin
        bit fall;
        if (!rst) begin
            m_edge++;
            if (!m_latched) begin
                m_six = sq_if.md;
                m_latched = 1'b1;
            end
            pin_q.push_back(sq_if.p7);
            m_lvl = pin_q[pin_q.size() - 1 - NS];
            if (pin_q.size() > NS + 1) void'(pin_q.pop_front());
            fall = m_prev_lvl && !m_lvl;
            m_tmo = 1'b0;
            if (fall) begin
                m_cnt = m_six ? ((m_cnt < 4) ? m_cnt + 1 : 4) : 0;
                m_last = m_edge;
            end else if (m_edge - m_last == TMO) begin
                m_tmo = (m_cnt != 0);
                m_cnt = 0;
                m_last = m_edge;
            end
            if (m_tmo) m_tmo_count++;
            m_prev_lvl = m_lvl;
            m_sel = exp_sel(m_lvl, m_cnt);
        end
    end

    // continuous checker: compares on any change and periodically otherwise
    int         cyc = 0;
    int         tmo_seen = 0;
    bit         bad_code = 1'b0;
    logic [2:0] prev_sel_obs, prev_sel_exp;
    logic       prev_p7s_obs, prev_six_obs;

    always @(negedge clk) begin
        if (!rst) begin
            cyc++;
            if (sq_if.tmo === 1'b1) tmo_seen++;
            if (sq_if.sel !== 3'd0 && sq_if.sel !== 3'd1) bad_code = 1'b1;
            if (sq_if.sel !== prev_sel_obs || m_sel !== prev_sel_exp || cyc % 64 == 0)
                chk("sel", sq_if.sel, m_sel);
            if (sq_if.tmo !== 1'b0 || m_tmo || cyc % 64 == 0)
                chk("tmo", sq_if.tmo, m_tmo);
            if (sq_if.p7_s !== prev_p7s_obs || cyc % 64 == 0)
                chk("p7_s", sq_if.p7_s, m_lvl);
            if (sq_if.six_mode !== prev_six_obs || cyc % 256 == 0)
                chk("six_mode", sq_if.six_mode, m_six);
            prev_sel_obs = sq_if.sel;
            prev_sel_exp = m_sel;
            prev_p7s_obs = sq_if.p7_s;
            prev_six_obs = sq_if.six_mode;
        end
    end

    task automatic half(input bit lvl, input int ncyc);
        sq_if.p7 = lvl;
        repeat (ncyc) @(negedge clk);
    endtask

    task automatic do_reset(input bit md_val, input int dly);
        sq_if.md = md_val;
        #(dly);
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_sel", sq_if.sel, 3'd1);
        chk("rst_p7_s", sq_if.p7_s, 1'b0);
        chk("rst_six", sq_if.six_mode, 1'b1);
        chk("rst_tmo", sq_if.tmo, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    int seq_exp[10] = '{1, 0, 1, 0, 2, 3, 4, 0, 4, 0};
    int tmo_mark;

    initial begin
        sq_if.p7 = 1'b1;
        sq_if.md = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);

        // idle with select high
        do_reset(1'b1, 3);
        half(1'b1, 4000);
        chk("idle_sel", sq_if.sel, 3'd0);
        chk("idle_tmo", tmo_seen, 0);

        // five select cycles, then timeout
        for (int i = 0; i < 5; i++) begin
            half(1'b0, 20);
            chk("seq_lo", sq_if.sel, seq_exp[2*i]);
            half(1'b1, 20);
            chk("seq_hi", sq_if.sel, seq_exp[2*i+1]);
        end
        tmo_mark = tmo_seen;
        half(1'b1, 2000);
        chk("tmo_once", tmo_seen - tmo_mark, 1);
        half(1'b0, 20);
        chk("after_tmo_sel", sq_if.sel, 3'd1);

        // fall on the exact expiry cycle, then expiry one cycle before a fall
        tmo_mark = tmo_seen;
        half(1'b1, TMO - 20);
        half(1'b0, 10);
        chk("edge_wins_tmo", tmo_seen - tmo_mark, 0);
        chk("edge_wins_sel", sq_if.sel, 3'd1);
        half(1'b1, TMO - 9);
        half(1'b0, 10);
        chk("tmo_then_edge", tmo_seen - tmo_mark, 1);
        chk("tmo_then_edge_sel", sq_if.sel, 3'd1);
        half(1'b1, 10);

        // random select traffic
        for (int r = 0; r < 8; r++) begin
            int nf;
            nf = $urandom_range(1, 6);
            for (int i = 0; i < nf; i++) begin
                half(1'b0, $urandom_range(1, 30));
                half(1'b1, $urandom_range(1, 30));
            end
            if ($urandom_range(0, 1) == 1) half(1'b1, TMO + $urandom_range(0, 50));
            else                            half(1'b1, $urandom_range(3, 200));
        end

        // forced three-button mode; md changes after the latch are ignored
        do_reset(1'b0, 7);
        bad_code = 1'b0;
        half(1'b1, 5);
        sq_if.md = 1'b1;
        for (int i = 0; i < 4; i++) begin
            half(1'b0, 20);
            half(1'b1, 20);
        end
        chk("three_btn_six", sq_if.six_mode, 1'b0);
        chk("three_btn_codes", bad_code, 1'b0);

        // sub-period glitches after a long idle phase
        do_reset(1'b1, 11);
        half(1'b1, 4000);
        bad_code = 1'b0;
        for (int g = 0; g < 4; g++) begin
            int d;
            d = $urandom_range(1, 79);
            if (d == 30 || d == 50) d = d + 1;
            #(d);
            sq_if.p7 = 1'b0;
            #20;
            sq_if.p7 = 1'b1;
            half(1'b1, TMO + 100);
        end
        chk("glitch_codes", bad_code, 1'b0);

        // reset in the middle of a six-button sequence
        do_reset(1'b1, 13);
        half(1'b1, 10);
        for (int i = 0; i < 3; i++) begin
            half(1'b0, 10);
            half(1'b1, 10);
        end
        chk("pre_rst_sel", sq_if.sel, 3'd3);
        do_reset(1'b1, $urandom_range(1, 40));
        half(1'b1, 10);
        half(1'b0, 10);
        chk("restart_sel", sq_if.sel, 3'd1);
        half(1'b1, 10);
        chk("restart_hi", sq_if.sel, 3'd0);

        chk("tmo_total", tmo_seen, m_tmo_count);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
